plane_life_ctrl: RTL and testbench
==================================

# plane_life_ctrl

Lifecycle controller for the player plane sprite in the VGA shooter. Sequences the plane through start, alive, hit/explosion animation, respawn with invincibility, and game over. Drives the plane sprite and explosion sprite selectors, the invincibility tint and the respawn request to the plane position logic. Consumes a per-frame tick from the VGA timing and a collision pulse from the pixel-overlap logic.

## Interface
- INIT_LIVES, 3: lives loaded at game start (1..3).
- INV_FRAMES, 120: invincibility length in frames after start/respawn (1..255).
- BOOM_FRAMES, 8: explosion animation frames (1..8).
- BOOM_HOLD, 4: frame ticks each animation frame is held (1..15).

- clk  in  1  system clock (pixel-domain clock).
- rst  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse per video frame (vsync start).
- hit  in  1  collision pulse: plane pixel overlapped enemy/bullet pixel.
- start  in  1  one-cycle game start/restart request.
- lives  out  2  remaining lives.
- invincible  out  1  invincibility active (drives tint override).
- show_plane  out  1  plane sprite enabled.
- boom_active  out  1  explosion sprite enabled.
- boom_frame  out  3  explosion animation index.
- respawn  out  1  one-cycle pulse: reload plane to home position (295,430).
- game_over  out  1  game over flag.

## Operation
- States: IDLE, ALIVE, EXPLODE, RESPAWN, OVER.
- IDLE: show_plane=0. start -> ALIVE; lives<=INIT_LIVES, inv_cnt<=INV_FRAMES, respawn pulse.
- ALIVE: show_plane=1. inv_cnt decrements on frame_tick while nonzero; invincible = (inv_cnt!=0). hit with inv_cnt==0 -> EXPLODE, lives<=lives-1, boom_frame<=0, hold_cnt<=BOOM_HOLD-1. hit while invincible ignored. start ignored.
- EXPLODE: show_plane=0, boom_active=1. Each frame_tick: hold_cnt==0 -> reload hold_cnt, boom_frame+1; otherwise hold_cnt-1. Leaving on the tick where boom_frame==BOOM_FRAMES-1 and hold_cnt==0: lives==0 -> OVER, else -> RESPAWN. hit and start ignored.
- RESPAWN: one cycle; respawn=1, inv_cnt<=INV_FRAMES, -> ALIVE.
- OVER: game_over=1, show_plane=0, boom_active=0. start -> behaves as IDLE start (lives reload, respawn pulse, -> ALIVE).
- lives never underflows: decrement only in ALIVE on accepted hit, lives>=1 there by construction.
- Counters: inv_cnt 8-bit, hold_cnt 4-bit, boom_frame 3-bit; no wrap beyond parameter bounds.

## Timing
- All outputs registered; reset values: lives=0, invincible=0, show_plane=0, boom_active=0, boom_frame=0, respawn=0, game_over=0, state IDLE.
- Input sampled at rising clk; effect visible on outputs next cycle (latency 1).
- start -> respawn high for exactly one cycle, the cycle after start; show_plane and invincible high the same cycle.
- hit and frame_tick same cycle in ALIVE: hit judged against registered inv_cnt before decrement; inv_cnt==1 with both -> hit ignored, inv_cnt->0.
- Explosion duration = BOOM_FRAMES*BOOM_HOLD frame ticks after hit.
- RESPAWN -> ALIVE: respawn pulse one cycle, invincible high from the RESPAWN-exit cycle.
- Reset asserted mid-operation: immediate return to reset values, regardless of state.

## Configuration
- PLANE_BLINK_EN defined: while invincible in ALIVE, show_plane toggles on every 8th frame_tick (blink counter, 3-bit, cleared on respawn); show_plane=1 when inv_cnt==0.
- Undefined: show_plane=1 throughout ALIVE; invincibility shown only via invincible tint.

## Structure
- Shared package plane_pkg: state enum (IDLE, ALIVE, EXPLODE, RESPAWN, OVER), home position constants (295,430), sprite size 50, screen bounds 640x480.
- One sub-module: tick_timer (loadable down-counter advanced by frame_tick, zero flag), instanced for inv_cnt and hold_cnt.

## Test plan
- Reset then start -> next cycle respawn=1 one cycle, lives=3, invincible=1, show_plane=1.
- 120 frame_ticks after start -> invincible=0; hit during first 120 ticks -> lives stays 3.
- hit with invincible=0 -> lives=2, boom_active=1; boom_frame steps 0..7 every 4 ticks; after 32 ticks respawn pulse, invincible=1.
- Three accepted hits -> after third explosion game_over=1, lives=0, no respawn; start -> lives=3, ALIVE.
- hit and frame_tick together with inv_cnt=1 -> hit ignored, invincible=0 next cycle.
- rst low during EXPLODE -> all outputs zero immediately, state IDLE; PLANE_BLINK_EN build: show_plane toggles every 8 ticks during invincibility.

Source files
------------

// File: rtl/plane_pkg.sv
// Shared definitions for the player plane: lifecycle states and playfield geometry.
package plane_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ALIVE,
    EXPLODE,
    RESPAWN,
    OVER
  } plane_state_e;

  localparam int HOME_X      = 295;
  localparam int HOME_Y      = 430;
  localparam int SPRITE_SIZE = 50;
  localparam int SCREEN_W    = 640;
  localparam int SCREEN_H    = 480;

endpackage

// File: rtl/plane_life_ctrl_tick_timer.sv
// tick_timer: loadable down-counter advanced by frame_tick, stopping at zero,
// with a registered zero flag.
module tick_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic         zero
);

  logic [W-1:0] cnt;
  logic [W-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (load)
      cnt_nxt = load_val;
    else if (tick && !zero)
      cnt_nxt = cnt - W'(1);
  end

  // Zero flag is registered alongside the count so it can drive outputs directly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      zero <= 1'b1;
    end else begin
      cnt  <= cnt_nxt;
      zero <= (cnt_nxt == '0);
    end
  end

endmodule

// File: rtl/plane_life_ctrl.sv
// Player plane lifecycle: start, alive/invincible, explosion, respawn, game over.
// Optional PLANE_BLINK_EN: plane sprite blinks every 8 frame ticks while invincible.
module plane_life_ctrl
  import plane_pkg::*;
#(
  parameter int INIT_LIVES  = 3,
  parameter int INV_FRAMES  = 120,
  parameter int BOOM_FRAMES = 8,
  parameter int BOOM_HOLD   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       hit,
  input  logic       start,
  output logic [1:0] lives,
  output logic       invincible,
  output logic       show_plane,
  output logic       boom_active,
  output logic [2:0] boom_frame,
  output logic       respawn,
  output logic       game_over
);

  localparam logic [1:0] LIVES_INIT = 2'(INIT_LIVES);
  localparam logic [7:0] INV_LOAD   = 8'(INV_FRAMES);
  localparam logic [3:0] HOLD_LOAD  = 4'(BOOM_HOLD - 1);
  localparam logic [2:0] LAST_FRAME = 3'(BOOM_FRAMES - 1);

  plane_state_e state;

  logic inv_zero;
  logic hold_zero;
  logic start_ok;
  logic hit_ok;
  logic inv_load;
  logic inv_tick;
  logic hold_load;
  logic hold_tick;
  logic boom_step;

`ifdef PLANE_BLINK_EN
  logic [2:0] blink_cnt;
`endif

  assign start_ok  = start && (state == IDLE || state == OVER);
  assign hit_ok    = hit && (state == ALIVE) && inv_zero;
  assign inv_load  = start_ok || (state == RESPAWN);
  assign inv_tick  = frame_tick && (state == ALIVE);
  assign hold_tick = frame_tick && (state == EXPLODE);
  assign boom_step = hold_tick && hold_zero;
  assign hold_load = hit_ok || boom_step;

  // The invincibility count is only ever nonzero in ALIVE, so its zero flag
  // doubles as the registered tint output.
  assign invincible = ~inv_zero;

  tick_timer #(.W(8)) u_inv_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (inv_load),
    .load_val (INV_LOAD),
    .tick     (inv_tick),
    .zero     (inv_zero)
  );

  tick_timer #(.W(4)) u_hold_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (hold_load),
    .load_val (HOLD_LOAD),
    .tick     (hold_tick),
    .zero     (hold_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      lives       <= 2'd0;
      show_plane  <= 1'b0;
      boom_active <= 1'b0;
      boom_frame  <= 3'd0;
      respawn     <= 1'b0;
      game_over   <= 1'b0;
`ifdef PLANE_BLINK_EN
      blink_cnt   <= 3'd0;
`endif
    end else begin
      respawn <= 1'b0;
      case (state)
        IDLE, OVER: begin
          if (start) begin
            state      <= ALIVE;
            lives      <= LIVES_INIT;
            show_plane <= 1'b1;
            respawn    <= 1'b1;
            game_over  <= 1'b0;
`ifdef PLANE_BLINK_EN
            blink_cnt  <= 3'd0;
`endif
          end
        end
        ALIVE: begin
          if (hit_ok) begin
            state       <= EXPLODE;
            lives       <= lives - 2'd1;
            show_plane  <= 1'b0;
            boom_active <= 1'b1;
            boom_frame  <= 3'd0;
          end
`ifdef PLANE_BLINK_EN
          else if (inv_zero) begin
            show_plane <= 1'b1;
          end else if (frame_tick) begin
            blink_cnt <= blink_cnt + 3'd1;
            if (blink_cnt == 3'd7)
              show_plane <= ~show_plane;
          end
`endif
        end
        EXPLODE: begin
          // Last animation frame fully held: decide between respawn and game over.
          if (boom_step) begin
            if (boom_frame == LAST_FRAME) begin
              boom_active <= 1'b0;
              boom_frame  <= 3'd0;
              if (lives == 2'd0) begin
                state     <= OVER;
                game_over <= 1'b1;
              end else begin
                state   <= RESPAWN;
                respawn <= 1'b1;
              end
            end else begin
              boom_frame <= boom_frame + 3'd1;
            end
          end
        end
        RESPAWN: begin
          state      <= ALIVE;
          show_plane <= 1'b1;
`ifdef PLANE_BLINK_EN
          blink_cnt  <= 3'd0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_plane_life_ctrl.sv
// Self-checking bench for plane_life_ctrl against a frame-count reference model.
module tb_plane_life_ctrl;

  localparam int INIT_LIVES  = 3;
  localparam int INV_FRAMES  = 120;
  localparam int BOOM_FRAMES = 8;
  localparam int BOOM_HOLD   = 4;
  localparam int BOOM_TICKS  = BOOM_FRAMES * BOOM_HOLD;

  localparam int M_IDLE  = 0;
  localparam int M_ALIVE = 1;
  localparam int M_BOOM  = 2;
  localparam int M_RESP  = 3;
  localparam int M_OVER  = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_tick;
  logic       hit;
  logic       start;
  logic [1:0] lives;
  logic       invincible;
  logic       show_plane;
  logic       boom_active;
  logic [2:0] boom_frame;
  logic       respawn;
  logic       game_over;

  int n_cmp = 0;
  int n_bad = 0;

  int m_mode;
  int m_lives;
  int m_inv;
  int m_elapsed;
  bit m_started;

  always #5 clk = ~clk;

  plane_life_ctrl #(
    .INIT_LIVES  (INIT_LIVES),
    .INV_FRAMES  (INV_FRAMES),
    .BOOM_FRAMES (BOOM_FRAMES),
    .BOOM_HOLD   (BOOM_HOLD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_tick  (frame_tick),
    .hit         (hit),
    .start       (start),
    .lives       (lives),
    .invincible  (invincible),
    .show_plane  (show_plane),
    .boom_active (boom_active),
    .boom_frame  (boom_frame),
    .respawn     (respawn),
    .game_over   (game_over)
  );

  task automatic model_reset();
    m_mode    = M_IDLE;
    m_lives   = 0;
    m_inv     = 0;
    m_elapsed = 0;
    m_started = 1'b0;
  endtask

  // Reference: plane state as frames remaining and explosion ticks elapsed.
  task automatic model_update(input bit st, input bit h, input bit ft);
    m_started = 1'b0;
    case (m_mode)
      M_IDLE, M_OVER: begin
        if (st) begin
          m_mode    = M_ALIVE;
          m_lives   = INIT_LIVES;
          m_inv     = INV_FRAMES;
          m_started = 1'b1;
        end
      end
      M_ALIVE: begin
        if (h && m_inv == 0) begin
          m_mode    = M_BOOM;
          m_lives   = m_lives - 1;
          m_elapsed = 0;
        end else if (ft && m_inv > 0) begin
          m_inv = m_inv - 1;
        end
      end
      M_BOOM: begin
        if (ft) begin
          m_elapsed = m_elapsed + 1;
          if (m_elapsed == BOOM_TICKS)
            m_mode = (m_lives == 0) ? M_OVER : M_RESP;
        end
      end
      M_RESP: begin
        m_mode = M_ALIVE;
        m_inv  = INV_FRAMES;
      end
      default: m_mode = M_IDLE;
    endcase
  endtask

  function automatic logic [9:0] exp_vec();
    logic [1:0] l;
    logic [2:0] f;
    int         ef;
    l  = m_lives[1:0];
    ef = (m_mode == M_BOOM) ? (m_elapsed / BOOM_HOLD) : 0;
    f  = ef[2:0];
    return {l, (m_mode == M_ALIVE && m_inv > 0), (m_mode == M_ALIVE),
            (m_mode == M_BOOM), f, (m_mode == M_RESP || m_started),
            (m_mode == M_OVER)};
  endfunction

  function automatic logic [9:0] dut_vec();
    return {lives, invincible, show_plane, boom_active, boom_frame, respawn, game_over};
  endfunction

  task automatic step(input bit st, input bit h, input bit ft);
    start      = st;
    hit        = h;
    frame_tick = ft;
    @(posedge clk);
    model_update(st, h, ft);
    #1;
    start      = 1'b0;
    hit        = 1'b0;
    frame_tick = 1'b0;
  endtask

  task automatic test_reset();
    start = 1'b0; hit = 1'b0; frame_tick = 1'b0;
    rst = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (dut_vec() !== 10'd0) begin
      n_bad++;
      $display("FAIL reset_values: got %03h expected %03h", dut_vec(), 10'd0);
    end
    rst = 1'b1;
    step(1'b0, 1'b1, 1'b1);
    n_cmp++;
    if (dut_vec() !== 10'd0) begin
      n_bad++;
      $display("FAIL idle_ignores_hit: got %03h expected %03h", dut_vec(), 10'd0);
    end
  endtask

  task automatic test_start();
    step(1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (respawn !== 1'b1 || lives !== 2'd3 || invincible !== 1'b1 || show_plane !== 1'b1) begin
      n_bad++;
      $display("FAIL start_outputs: got resp=%b lives=%0d inv=%b show=%b expected 1 3 1 1",
               respawn, lives, invincible, show_plane);
    end
    step(1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (respawn !== 1'b0 || dut_vec() !== exp_vec()) begin
      n_bad++;
      $display("FAIL start_pulse_len: got %03h expected %03h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_invincibility();
    for (int i = 1; i < INV_FRAMES; i++) begin
      step(1'b0, ($urandom_range(0, 1) != 0), 1'b1);
      n_cmp++;
      if (lives !== 2'd3 || invincible !== 1'b1) begin
        n_bad++;
        $display("FAIL inv_hit_ignored tick %0d: got lives=%0d inv=%b expected 3 1",
                 i, lives, invincible);
      end
    end
  endtask

  task automatic test_hit_tick_boundary();
    step(1'b0, 1'b1, 1'b1);
    n_cmp++;
    if (invincible !== 1'b0 || lives !== 2'd3 || boom_active !== 1'b0 || show_plane !== 1'b1) begin
      n_bad++;
      $display("FAIL hit_tick_inv1: got inv=%b lives=%0d boom=%b show=%b expected 0 3 0 1",
               invincible, lives, boom_active, show_plane);
    end
    n_cmp++;
    if (dut_vec() !== exp_vec()) begin
      n_bad++;
      $display("FAIL hit_tick_model: got %03h expected %03h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_explosion();
    step(1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (lives !== 2'd2 || boom_active !== 1'b1 || boom_frame !== 3'd0 || show_plane !== 1'b0) begin
      n_bad++;
      $display("FAIL hit_accept: got lives=%0d boom=%b frame=%0d show=%b expected 2 1 0 0",
               lives, boom_active, boom_frame, show_plane);
    end
    for (int k = 1; k <= BOOM_TICKS; k++) begin
      step(($urandom_range(0, 1) != 0), ($urandom_range(0, 1) != 0), 1'b1);
      n_cmp++;
      if (k < BOOM_TICKS) begin
        if (boom_active !== 1'b1 || boom_frame !== 3'(k / BOOM_HOLD) || lives !== 2'd2) begin
          n_bad++;
          $display("FAIL boom_frame tick %0d: got act=%b frame=%0d lives=%0d expected 1 %0d 2",
                   k, boom_active, boom_frame, lives, k / BOOM_HOLD);
        end
      end else if (respawn !== 1'b1 || boom_active !== 1'b0 || game_over !== 1'b0) begin
        n_bad++;
        $display("FAIL boom_end: got resp=%b act=%b over=%b expected 1 0 0",
                 respawn, boom_active, game_over);
      end
      if (k < BOOM_TICKS) step(1'b0, 1'b0, 1'b0);
    end
    step(1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (invincible !== 1'b1 || respawn !== 1'b0 || show_plane !== 1'b1 || lives !== 2'd2) begin
      n_bad++;
      $display("FAIL respawn_exit: got inv=%b resp=%b show=%b lives=%0d expected 1 0 1 2",
               invincible, respawn, show_plane, lives);
    end
  endtask

  task automatic test_game_over();
    for (int life = 0; life < 2; life++) begin
      int guard = 0;
      while (!(m_mode == M_ALIVE && m_inv == 0) && guard < 400) begin
        step(1'b0, 1'b0, 1'b1);
        guard++;
        n_cmp++;
        if (dut_vec() !== exp_vec()) begin
          n_bad++;
          $display("FAIL go_run_inv: got %03h expected %03h", dut_vec(), exp_vec());
        end
      end
      if (guard >= 400) begin
        n_bad++;
        $display("FAIL go_inv_timeout: got mode %0d expected %0d", m_mode, M_ALIVE);
      end
      step(1'b0, 1'b1, 1'b0);
      for (int k = 0; k < BOOM_TICKS; k++) begin
        step(1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (dut_vec() !== exp_vec()) begin
          n_bad++;
          $display("FAIL go_boom tick %0d: got %03h expected %03h", k, dut_vec(), exp_vec());
        end
      end
    end
    n_cmp++;
    if (game_over !== 1'b1 || lives !== 2'd0 || respawn !== 1'b0 || show_plane !== 1'b0 ||
        boom_active !== 1'b0) begin
      n_bad++;
      $display("FAIL game_over: got over=%b lives=%0d resp=%b show=%b boom=%b expected 1 0 0 0 0",
               game_over, lives, respawn, show_plane, boom_active);
    end
    repeat (3) step(1'b0, 1'b1, 1'b1);
    n_cmp++;
    if (dut_vec() !== exp_vec() || game_over !== 1'b1) begin
      n_bad++;
      $display("FAIL over_hold: got %03h expected %03h", dut_vec(), exp_vec());
    end
    step(1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (lives !== 2'd3 || respawn !== 1'b1 || game_over !== 1'b0 || show_plane !== 1'b1) begin
      n_bad++;
      $display("FAIL restart: got lives=%0d resp=%b over=%b show=%b expected 3 1 0 1",
               lives, respawn, game_over, show_plane);
    end
  endtask

  task automatic test_reset_mid_explode();
    int guard = 0;
    while (!(m_mode == M_ALIVE && m_inv == 0) && guard < 400) begin
      step(1'b0, 1'b0, 1'b1);
      guard++;
    end
    step(1'b0, 1'b1, 1'b0);
    repeat (10) step(1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (boom_active !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_reset_boom: got %b expected 1", boom_active);
    end
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    n_cmp++;
    if (dut_vec() !== 10'd0) begin
      n_bad++;
      $display("FAIL async_reset: got %03h expected %03h", dut_vec(), 10'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(1'b0, 1'b1, 1'b1);
    n_cmp++;
    if (dut_vec() !== 10'd0) begin
      n_bad++;
      $display("FAIL reset_to_idle: got %03h expected %03h", dut_vec(), 10'd0);
    end
    step(1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (lives !== 2'd3 || respawn !== 1'b1) begin
      n_bad++;
      $display("FAIL start_after_reset: got lives=%0d resp=%b expected 3 1", lives, respawn);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 15),
           ($urandom_range(0, 99) < 40));
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL random cycle %0d: got %03h expected %03h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_invincibility();
    test_hit_tick_boundary();
    test_explosion();
    test_game_over();
    test_reset_mid_explode();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
